// File: rtl/pc_fetch_sequencer.sv
// Fetch controller: issues one imem request at a time from the PC, steers the PC
// register (PC+4 or redirect) and hands fetched words to decode via valid/ready.
module pc_fetch_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0040_0000,
    parameter int unsigned MAX_WAIT = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc_i,
    output logic        pc_en_o,
    output logic [31:0] pc_next_o,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ack_i,
    input  logic [31:0] imem_rdata_i,
    output logic        instr_valid_o,
    output logic [31:0] instr_o,
    output logic [31:0] instr_pc_o,
    input  logic        decode_ready_i,
    input  logic        stall_i,
    input  logic        branch_taken_i,
    input  logic [31:0] branch_target_i,
    input  logic        jump_i,
    input  logic [31:0] jump_target_i,
    output logic        fetch_fault_o
);

    if (RESET_PC[1:0] != 2'b00 || MAX_WAIT < 1 || MAX_WAIT > 255) begin : g_param_check
        $error("pc_fetch_sequencer: misaligned RESET_PC or MAX_WAIT outside 1..255");
    end

    typedef enum logic [1:0] {IDLE, REQ, HOLD, FAULT} state_t;

    state_t      state_q, state_d;
    logic        req_q, req_d;
    logic [31:0] addr_q, addr_d;
    logic        valid_q, valid_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] ipc_q, ipc_d;
    logic        fault_q, fault_d;
    logic        drop_q, drop_d;
    logic [7:0]  cnt_q, cnt_d;

    logic        redirect;
    logic [31:0] redir_target;
    logic [31:0] entry_addr;
    logic        refetch;

    always_comb begin
        redirect     = !rst && (jump_i || branch_taken_i) && (state_q != FAULT);
        redir_target = jump_i ? jump_target_i : branch_target_i;
        // The PC register only takes a redirect at this edge, so a fetch entered
        // in the same cycle must use the target rather than the stale pc_i.
        entry_addr   = redirect ? redir_target : pc_i;
        refetch      = 1'b0;

        state_d   = state_q;
        req_d     = req_q;
        addr_d    = addr_q;
        valid_d   = valid_q;
        instr_d   = instr_q;
        ipc_d     = ipc_q;
        fault_d   = fault_q;
        drop_d    = drop_q;
        cnt_d     = cnt_q;
        pc_en_o   = 1'b0;
        pc_next_o = '0;

        if (redirect) begin
            pc_en_o   = 1'b1;
            pc_next_o = redir_target;
        end

        case (state_q)
            IDLE: refetch = 1'b1;
            REQ: begin
                if (imem_ack_i) begin
                    if (drop_q) begin
                        drop_d  = 1'b0;
                        refetch = 1'b1;
                    end else if (redirect) begin
                        refetch = 1'b1;
                    end else begin
                        instr_d   = imem_rdata_i;
                        ipc_d     = addr_q;
                        valid_d   = 1'b1;
                        req_d     = 1'b0;
                        pc_en_o   = 1'b1;
                        pc_next_o = addr_q + 32'd4;
                        state_d   = HOLD;
                    end
                end else if (cnt_q == 8'(MAX_WAIT - 1)) begin
                    state_d = FAULT;
                    req_d   = 1'b0;
                    valid_d = 1'b0;
                    fault_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                    if (redirect) begin
                        drop_d = 1'b1;
                    end
                end
            end
            HOLD: begin
                if (redirect || decode_ready_i) begin
                    valid_d = 1'b0;
                    refetch = 1'b1;
                end
            end
            default: ;
        endcase

        if (refetch) begin
            if (stall_i) begin
                state_d = IDLE;
                req_d   = 1'b0;
            end else if (entry_addr[1:0] != 2'b00) begin
                state_d = FAULT;
                req_d   = 1'b0;
                valid_d = 1'b0;
                fault_d = 1'b1;
            end else begin
                state_d = REQ;
                req_d   = 1'b1;
                addr_d  = entry_addr;
                cnt_d   = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            req_q   <= 1'b0;
            addr_q  <= '0;
            valid_q <= 1'b0;
            instr_q <= '0;
            ipc_q   <= '0;
            fault_q <= 1'b0;
            drop_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            addr_q  <= addr_d;
            valid_q <= valid_d;
            instr_q <= instr_d;
            ipc_q   <= ipc_d;
            fault_q <= fault_d;
            drop_q  <= drop_d;
            cnt_q   <= cnt_d;
        end
    end

    assign imem_req_o    = req_q;
    assign imem_addr_o   = addr_q;
    assign instr_valid_o = valid_q;
    assign instr_o       = instr_q;
    assign instr_pc_o    = ipc_q;
    assign fetch_fault_o = fault_q;

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Directed bench for pc_fetch_sequencer; the bench owns the PC register and the
// instruction memory, which returns (address ^ 32'hDEAD_0000) as data.
module tb_pc_fetch_sequencer;

    localparam logic [31:0] RESET_PC = 32'h0040_0000;
    localparam logic [31:0] DKEY     = 32'hDEAD_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc_q;
    logic        pc_en_o;
    logic [31:0] pc_next_o;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_ack_i;
    logic [31:0] imem_rdata_i;
    logic        instr_valid_o;
    logic [31:0] instr_o;
    logic [31:0] instr_pc_o;
    logic        decode_ready_i;
    logic        stall_i;
    logic        branch_taken_i;
    logic [31:0] branch_target_i;
    logic        jump_i;
    logic [31:0] jump_target_i;
    logic        fetch_fault_o;

    int n_tests = 0;
    int n_fail  = 0;

    pc_fetch_sequencer #(.RESET_PC(RESET_PC), .MAX_WAIT(15)) dut (
        .clk(clk), .rst(rst), .pc_i(pc_q), .pc_en_o(pc_en_o), .pc_next_o(pc_next_o),
        .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o), .imem_ack_i(imem_ack_i),
        .imem_rdata_i(imem_rdata_i), .instr_valid_o(instr_valid_o), .instr_o(instr_o),
        .instr_pc_o(instr_pc_o), .decode_ready_i(decode_ready_i), .stall_i(stall_i),
        .branch_taken_i(branch_taken_i), .branch_target_i(branch_target_i),
        .jump_i(jump_i), .jump_target_i(jump_target_i), .fetch_fault_o(fetch_fault_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rst) pc_q <= RESET_PC;
        else if (pc_en_o) pc_q <= pc_next_o;
    end

    assign imem_rdata_i = imem_addr_o ^ DKEY;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Entered just after the edge that put the DUT in REQ for address a.
    task automatic fetch_one(input logic [31:0] a);
        check("req", 32'(imem_req_o), 32'd1);
        check("addr", imem_addr_o, a);
        imem_ack_i = 1'b1;
        #1;
        check("pc_en_ack", 32'(pc_en_o), 32'd1);
        check("pc_next_ack", pc_next_o, a + 32'd4);
        tick();
        imem_ack_i     = 1'b0;
        decode_ready_i = 1'b0;
        check("valid", 32'(instr_valid_o), 32'd1);
        check("instr", instr_o, a ^ DKEY);
        check("instr_pc", instr_pc_o, a);
        check("req_hold", 32'(imem_req_o), 32'd0);
        check("pc_after_ack", pc_q, a + 32'd4);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; imem_ack_i = 1'b0; decode_ready_i = 1'b0; stall_i = 1'b0;
        branch_taken_i = 1'b0; branch_target_i = '0; jump_i = 1'b1; jump_target_i = 32'h0040_0010;
        tick(); tick();
        check("rst_req", 32'(imem_req_o), 32'd0);
        check("rst_addr", imem_addr_o, 32'd0);
        check("rst_valid", 32'(instr_valid_o), 32'd0);
        check("rst_instr", instr_o, 32'd0);
        check("rst_fault", 32'(fetch_fault_o), 32'd0);
        check("rst_pc_en", 32'(pc_en_o), 32'd0);
        check("rst_pc_next", pc_next_o, 32'd0);
        check("rst_pc", pc_q, RESET_PC);
        jump_i = 1'b0;
        rst    = 1'b0;
        #1;
        check("idle_req", 32'(imem_req_o), 32'd0);
        tick();

        // sequential fetches, one per two cycles
        fetch_one(32'h0040_0000);
        decode_ready_i = 1'b1; tick(); decode_ready_i = 1'b0;
        check("flushed_valid", 32'(instr_valid_o), 32'd0);
        fetch_one(32'h0040_0004);
        decode_ready_i = 1'b1; tick(); decode_ready_i = 1'b0;
        fetch_one(32'h0040_0008);

        // decode back-pressure
        for (int i = 0; i < 3; i++) begin
            tick();
            check("bp_valid", 32'(instr_valid_o), 32'd1);
            check("bp_instr", instr_o, 32'h0040_0008 ^ DKEY);
            check("bp_ipc", instr_pc_o, 32'h0040_0008);
            check("bp_req", 32'(imem_req_o), 32'd0);
            check("bp_pc_en", 32'(pc_en_o), 32'd0);
        end

        // jump while holding an instruction
        jump_i = 1'b1; jump_target_i = 32'h0040_0100;
        #1;
        check("jmp_pc_en", 32'(pc_en_o), 32'd1);
        check("jmp_pc_next", pc_next_o, 32'h0040_0100);
        tick();
        jump_i = 1'b0;
        check("jmp_flush", 32'(instr_valid_o), 32'd0);
        check("jmp_req", 32'(imem_req_o), 32'd1);
        check("jmp_addr", imem_addr_o, 32'h0040_0100);
        check("jmp_pc", pc_q, 32'h0040_0100);

        // branch during an outstanding request, ack arrives later
        branch_taken_i = 1'b1; branch_target_i = 32'h0040_0200;
        #1;
        check("br_pc_en", 32'(pc_en_o), 32'd1);
        check("br_pc_next", pc_next_o, 32'h0040_0200);
        tick();
        branch_taken_i = 1'b0;
        check("br_addr_held1", imem_addr_o, 32'h0040_0100);
        check("br_pc", pc_q, 32'h0040_0200);
        tick();
        check("br_addr_held2", imem_addr_o, 32'h0040_0100);
        check("br_req_held", 32'(imem_req_o), 32'd1);
        imem_ack_i = 1'b1;
        #1;
        check("drop_pc_en", 32'(pc_en_o), 32'd0);
        tick();
        imem_ack_i = 1'b0;
        check("drop_valid", 32'(instr_valid_o), 32'd0);
        check("br_tgt_addr", imem_addr_o, 32'h0040_0200);
        check("br_tgt_req", 32'(imem_req_o), 32'd1);

        // jump and branch together with ack in the same cycle
        jump_i = 1'b1; jump_target_i = 32'h0040_0300;
        branch_taken_i = 1'b1; branch_target_i = 32'h0040_0400;
        imem_ack_i = 1'b1;
        #1;
        check("jb_pc_next", pc_next_o, 32'h0040_0300);
        tick();
        jump_i = 1'b0; branch_taken_i = 1'b0; imem_ack_i = 1'b0;
        check("jb_valid", 32'(instr_valid_o), 32'd0);
        check("jb_addr", imem_addr_o, 32'h0040_0300);

        // ack on the 15th REQ cycle is still accepted
        for (int i = 0; i < 14; i++) tick();
        check("w14_fault", 32'(fetch_fault_o), 32'd0);
        fetch_one(32'h0040_0300);
        check("w15_fault", 32'(fetch_fault_o), 32'd0);

        // no ack for 15 cycles -> fault
        decode_ready_i = 1'b1; tick(); decode_ready_i = 1'b0;
        check("to_addr", imem_addr_o, 32'h0040_0304);
        for (int i = 0; i < 14; i++) tick();
        check("to_req14", 32'(imem_req_o), 32'd1);
        check("to_fault14", 32'(fetch_fault_o), 32'd0);
        tick();
        check("to_fault", 32'(fetch_fault_o), 32'd1);
        check("to_req", 32'(imem_req_o), 32'd0);
        jump_i = 1'b1; imem_ack_i = 1'b1; decode_ready_i = 1'b1;
        #1;
        check("flt_pc_en", 32'(pc_en_o), 32'd0);
        tick(); tick();
        check("flt_sticky", 32'(fetch_fault_o), 32'd1);
        check("flt_req", 32'(imem_req_o), 32'd0);
        check("flt_valid", 32'(instr_valid_o), 32'd0);
        jump_i = 1'b0; imem_ack_i = 1'b0; decode_ready_i = 1'b0;

        // misaligned redirect target
        rst = 1'b1; tick(); rst = 1'b0;
        check("rst2_fault", 32'(fetch_fault_o), 32'd0);
        tick();
        fetch_one(32'h0040_0000);
        jump_i = 1'b1; jump_target_i = 32'h0040_0102;
        tick();
        jump_i = 1'b0;
        check("mis_fault", 32'(fetch_fault_o), 32'd1);
        check("mis_req", 32'(imem_req_o), 32'd0);
        check("mis_pc", pc_q, 32'h0040_0102);
        tick();
        check("mis_req2", 32'(imem_req_o), 32'd0);

        // reset in the middle of a request
        rst = 1'b1; tick(); rst = 1'b0; tick();
        check("mid_req", 32'(imem_req_o), 32'd1);
        rst = 1'b1; jump_i = 1'b1;
        #1;
        check("mid_pc_en", 32'(pc_en_o), 32'd0);
        check("mid_pc_next", pc_next_o, 32'd0);
        tick();
        check("mid_req_rst", 32'(imem_req_o), 32'd0);
        check("mid_addr_rst", imem_addr_o, 32'd0);
        check("mid_ipc_rst", instr_pc_o, 32'd0);
        check("mid_fault_rst", 32'(fetch_fault_o), 32'd0);
        rst = 1'b0; jump_i = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
